// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } e_arb_state;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational grant picker for mem_arbiter.
// Default: round-robin starting one above last_grant, with wrap-around.
// MEM_ARB_FIXED_PRIORITY_EN defined: lowest-index pending port wins, last_grant ignored.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 2,
  localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     grant,
  output logic                 valid
);

  logic [IDX_W-1:0] cand;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // First pending port from index 0 upward.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'(i);
      if (!valid && pending[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end
`else
  // First pending port searching upward from last_grant+1, wrapping.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = IDX_W'((32'(last_grant) + i) % NUM_PORTS);
      if (!valid && pending[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: captures per-port request pulses and serialises them onto a
// single memory port, one transaction at a time.
// Build option: MEM_ARB_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W    = MEM_ARB_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wr_data,
  input  logic [NUM_PORTS-1:0]        req_rd,
  input  logic [NUM_PORTS-1:0]        req_wr,
  output logic [NUM_PORTS-1:0]        req_ack,
  output logic [DATA_W-1:0]           req_rd_data,
  output logic [NUM_PORTS-1:0]        req_pending,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wr_data,
  output logic                        mem_rd_req,
  output logic                        mem_wr_req,
  input  logic [DATA_W-1:0]           mem_rd_data,
  input  logic                        mem_ack,
  input  logic                        mem_busy
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  e_arb_state           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0] pending_q, pending_d;
  logic [NUM_PORTS-1:0] is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]    addr_q [NUM_PORTS];
  logic [ADDR_W-1:0]    addr_d [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_q [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_ack_q, req_ack_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wr_data_q, mem_wr_data_d;
  logic                 mem_rd_req_q, mem_rd_req_d;
  logic                 mem_wr_req_q, mem_wr_req_d;

  logic [IDX_W-1:0]     pick_grant;
  logic                 pick_valid;
  logic                 issue;
  logic [IDX_W-1:0]     issue_idx;
  logic [NUM_PORTS-1:0] clear;

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // Next-state: arbitration FSM, memory issue, completion, request capture.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    pending_d     = pending_q;
    is_wr_d       = is_wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    req_ack_d     = '0;
    rd_data_d     = rd_data_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_rd_req_d  = 1'b0;
    mem_wr_req_d  = 1'b0;
    issue         = 1'b0;
    issue_idx     = grant_q;
    clear         = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          if (!mem_busy) begin
            issue     = 1'b1;
            issue_idx = pick_grant;
            state_d   = ARB_WAIT;
          end else begin
            state_d = ARB_ISSUE;
          end
        end
      end
      ARB_ISSUE: begin
        if (!mem_busy) begin
          issue   = 1'b1;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_ack) begin
          req_ack_d[grant_q] = 1'b1;
          if (!is_wr_q[grant_q]) rd_data_d = mem_rd_data;
          clear[grant_q] = 1'b1;
          last_grant_d   = grant_q;
          state_d        = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (issue) begin
      mem_addr_d    = addr_q[issue_idx];
      mem_wr_data_d = wdata_q[issue_idx];
      mem_wr_req_d  = is_wr_q[issue_idx];
      mem_rd_req_d  = !is_wr_q[issue_idx];
    end

    // A pulse on the same edge as its own ack clear is captured (set wins).
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      pending_d[p] = pending_q[p] & ~clear[p];
      if ((req_rd[p] || req_wr[p]) && (!pending_q[p] || clear[p])) begin
        pending_d[p] = 1'b1;
        is_wr_d[p]   = req_wr[p];
        addr_d[p]    = req_addr[p*ADDR_W +: ADDR_W];
        wdata_d[p]   = req_wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

  // State and registered outputs; async reset parks last_grant so port 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_PORTS - 1);
      pending_q     <= '0;
      is_wr_q       <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        addr_q[p]  <= '0;
        wdata_q[p] <= '0;
      end
      req_ack_q     <= '0;
      rd_data_q     <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_wr_req_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      pending_q     <= pending_d;
      is_wr_q       <= is_wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      req_ack_q     <= req_ack_d;
      rd_data_q     <= rd_data_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_rd_req_q  <= mem_rd_req_d;
      mem_wr_req_q  <= mem_wr_req_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign req_rd_data = rd_data_q;
  assign req_pending = pending_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_rd_req  = mem_rd_req_q;
  assign mem_wr_req  = mem_wr_req_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (two ports, 32-bit address/data).
module tb_mem_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wr_data;
  logic [NP-1:0]   req_rd, req_wr, req_ack, req_pending;
  logic [DW-1:0]   req_rd_data;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wr_data, mem_rd_data;
  logic            mem_rd_req, mem_wr_req, mem_ack, mem_busy;
  logic            auto_ack;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_addr    (req_addr),
    .req_wr_data (req_wr_data),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_ack     (req_ack),
    .req_rd_data (req_rd_data),
    .req_pending (req_pending),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_req  (mem_rd_req),
    .mem_wr_req  (mem_wr_req),
    .mem_rd_data (mem_rd_data),
    .mem_ack     (mem_ack),
    .mem_busy    (mem_busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { int port; logic [31:0] data; } ack_t;
  typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } mem_t;
  ack_t ack_q[$];
  mem_t mem_q[$];
  ack_t ea;
  mem_t em;
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected completion; a write returns the previous read data unchanged.
  task automatic exp_ack(input int port, input logic wr, input logic [31:0] rdata);
    if (!wr) last_rd = rdata;
    ack_q.push_back('{port, last_rd});
  endtask

  task automatic exp_mem(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    mem_q.push_back('{wr, addr, wdata});
  endtask

  task automatic pulse(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk); #1;
    req_rd = rd; req_wr = wr;
    req_addr = {a1, a0}; req_wr_data = {d1, d0};
    @(posedge clk); #1;
    req_rd = '0; req_wr = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((req_pending != '0 || ack_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n < 100), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Memory responder: ack one cycle after each request pulse.
  initial begin
    logic [31:0] ra;
    forever begin
      @(posedge clk); #1;
      if (auto_ack && (mem_rd_req || mem_wr_req)) begin
        ra = mem_addr;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        mem_rd_data = (ra == 32'h40) ? 32'hDEADBEEF : {ra[15:0], 16'hC0DE};
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
    end
  end

  // Monitor: compare every completion and memory pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ack !== '0) begin
        if (ack_q.size() == 0) chk("unexpected_ack", 64'(req_ack), 64'd0);
        else begin
          ea = ack_q.pop_front();
          chk("ack_port", 64'(req_ack), 64'(1) << ea.port);
          chk("ack_data", 64'(req_rd_data), 64'(ea.data));
        end
      end
      if (mem_rd_req || mem_wr_req) begin
        if (mem_q.size() == 0) chk("unexpected_mem_req", {mem_rd_req, mem_wr_req}, 64'd0);
        else begin
          em = mem_q.pop_front();
          chk("mem_wr_req", 64'(mem_wr_req), 64'(em.wr));
          chk("mem_rd_req", 64'(mem_rd_req), 64'(!em.wr));
          chk("mem_addr", 64'(mem_addr), 64'(em.addr));
          if (em.wr) chk("mem_wr_data", 64'(mem_wr_data), 64'(em.wdata));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; auto_ack = 1'b1; mem_busy = 1'b0; mem_ack = 1'b0; mem_rd_data = '0;
    req_rd = '0; req_wr = '0; req_addr = '0; req_wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    chk("rst_rd_data", 64'(req_rd_data), 64'd0);
    chk("rst_pending", 64'(req_pending), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_pulses", {mem_rd_req, mem_wr_req}, 64'd0);
    rst = 1'b0;

    // Single read with cycle-exact latency.
    exp_mem(1'b0, 32'h40, 32'h0);
    exp_ack(0, 1'b0, 32'hDEADBEEF);
    pulse(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0);
    @(negedge clk); chk("t1_no_early_req", 64'(mem_rd_req), 64'd0);
    @(negedge clk); chk("t1_rd_req_e1", 64'(mem_rd_req), 64'd1);
    chk("t1_addr_e1", 64'(mem_addr), 64'h40);
    @(negedge clk); chk("t1_no_ack_e2", 64'(req_ack), 64'd0);
    @(negedge clk); chk("t1_ack_e3", 64'(req_ack), 64'b01);
    chk("t1_data_e3", 64'(req_rd_data), 64'hDEADBEEF);
    wait_idle("t1_idle");

    // Busy stall on port 1.
    mem_busy = 1'b1;
    exp_mem(1'b0, 32'h300, 32'h0);
    exp_ack(1, 1'b0, 32'h0300C0DE);
    pulse(2'b10, 2'b00, 32'h0, 32'h0, 32'h300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_no_pulse", {mem_rd_req, mem_wr_req}, 64'd0);
      chk("busy_pending", 64'(req_pending), 64'b10);
    end
    mem_busy = 1'b0;
    @(negedge clk); chk("busy_release_pulse", 64'(mem_rd_req), 64'd1);
    wait_idle("busy_idle");

    // Contention A: port 0 read and port 1 write together; port 0 first in both modes.
    exp_mem(1'b0, 32'h100, 32'h0);
    exp_mem(1'b1, 32'h200, 32'h55);
    exp_ack(0, 1'b0, 32'h0100C0DE);
    exp_ack(1, 1'b1, 32'h0);
    pulse(2'b01, 2'b10, 32'h100, 32'h0, 32'h200, 32'h55);
    wait_idle("pairA_idle");

    // Read and write pulsed together is a write.
    exp_mem(1'b1, 32'h700, 32'h77);
    exp_ack(1, 1'b1, 32'h0);
    pulse(2'b10, 2'b10, 32'h0, 32'h0, 32'h700, 32'h77);
    wait_idle("simul_idle");

    // Duplicate pulse while pending is dropped.
    exp_mem(1'b0, 32'h500, 32'h0);
    exp_ack(0, 1'b0, 32'h0500C0DE);
    pulse(2'b01, 2'b00, 32'h500, 32'h0, 32'h0, 32'h0);
    pulse(2'b01, 2'b00, 32'h600, 32'h0, 32'h0, 32'h0);
    wait_idle("dup_idle");

    // Contention B after port 0 was served last.
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    exp_mem(1'b0, 32'h180, 32'h0);
    exp_mem(1'b1, 32'h280, 32'hAA);
    exp_ack(0, 1'b0, 32'h0180C0DE);
    exp_ack(1, 1'b1, 32'h0);
`else
    exp_mem(1'b1, 32'h280, 32'hAA);
    exp_mem(1'b0, 32'h180, 32'h0);
    exp_ack(1, 1'b1, 32'h0);
    exp_ack(0, 1'b0, 32'h0180C0DE);
`endif
    pulse(2'b01, 2'b10, 32'h180, 32'h0, 32'h280, 32'hAA);
    wait_idle("pairB_idle");

    // Spurious ack while idle.
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    chk("spur_no_ack", 64'(req_ack), 64'd0);
    chk("spur_pending", 64'(req_pending), 64'd0);
    exp_mem(1'b0, 32'h40, 32'h0);
    exp_ack(0, 1'b0, 32'hDEADBEEF);
    pulse(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0);
    wait_idle("spur_after_idle");

    // Reset in ARB_WAIT; late ack afterwards is discarded.
    auto_ack = 1'b0;
    exp_mem(1'b0, 32'h900, 32'h0);
    pulse(2'b01, 2'b00, 32'h900, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_pending", 64'(req_pending), 64'd0);
    chk("rst_mid_addr", 64'(mem_addr), 64'd0);
    chk("rst_mid_rd_data", 64'(req_rd_data), 64'd0);
    @(negedge clk); rst = 1'b0;
    last_rd = '0;
    mem_ack = 1'b1; mem_rd_data = 32'h12345678;
    @(negedge clk); mem_ack = 1'b0;
    chk("late_ack_ignored", 64'(req_ack), 64'd0);
    @(negedge clk);
    chk("late_ack_ignored2", 64'(req_ack), 64'd0);
    chk("late_rd_data", 64'(req_rd_data), 64'd0);
    chk("late_pending", 64'(req_pending), 64'd0);
    auto_ack = 1'b1;
    exp_mem(1'b0, 32'hA00, 32'h0);
    exp_ack(1, 1'b0, 32'h0A00C0DE);
    pulse(2'b10, 2'b00, 32'h0, 32'h0, 32'hA00, 32'h0);
    wait_idle("fresh_idle");

    chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
    chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
